// File: rtl/bram_dp_lat_pkg.sv
// Shared types and helpers for the latency-emulating dual-port block RAM.
package bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } port_state_e;

  localparam int LAT_MAX = 255;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_dp_lat_if.sv
// One RAM port: request (en/we/addr/di) with ready, read data with valid strobe.
interface bram_dp_lat_if
  import bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  en;
  logic [DATA_W/8-1:0]   we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     di;
  logic                  rdy;
  logic [DATA_W-1:0]     dout;
  logic                  dvld;

  modport master (output en, we, addr, di, input rdy, dout, dvld);
  modport slave  (input en, we, addr, di, output rdy, dout, dvld);
endinterface

// File: rtl/bram_dp_lat_port_ctl.sv
// Per-port handshake FSM: counts the programmed latency, then presents the held read word.
// Accepts whenever not in WAIT; a read accepted in DONE chains straight into the next wait.
module bram_port_ctl
  import bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAT    = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              is_wr,
  input  logic [DATA_W-1:0] hold,
  output logic              rdy,
  output logic              acc_wr,
  output logic              acc_rd,
  output logic [DATA_W-1:0] dout,
  output logic              dvld
);
  localparam int CW = clog2(LAT + 1);

  port_state_e   st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  assign rdy    = (st != ST_WAIT);
  assign acc_wr = en & rdy & is_wr;
  assign acc_rd = en & rdy & ~is_wr;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      ST_IDLE, ST_DONE: begin
        st_nxt = ST_IDLE;
        if (acc_rd) begin
          cnt_nxt = CW'(LAT - 1);
          st_nxt  = (LAT == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) st_nxt = ST_DONE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // DO/DVLD are registered out of DONE, so a read accepted at edge t lands at edge t+LAT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st   <= ST_IDLE;
      cnt  <= '0;
      dout <= '0;
      dvld <= 1'b0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      dvld <= (st == ST_DONE);
      if (st == ST_DONE) dout <= hold;
    end
  end

endmodule

// File: rtl/bram_dp_lat.sv
// True dual-port byte-enabled block RAM with programmable read latency per port.
// Port A wins per byte when both ports write the same word at the same edge.
module bram_dp_lat
  import bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 32,
  parameter int LAT    = 10
) (
  input  logic          CLK,
  input  logic          RST,
  bram_dp_lat_if.slave  port_a,
  bram_dp_lat_if.slave  port_b
);
  localparam int IW = clog2(DEPTH);
  localparam int NB = DATA_W / 8;

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        LAT < 1 || LAT > LAT_MAX || ADDR_W < IW) begin : g_param_err
      $error("bram_dp_lat: illegal parameter combination");
    end
  endgenerate

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0]     idx_a, idx_b;
  logic              wr_a, rd_a, wr_b, rd_b;
  logic [DATA_W-1:0] hold_a, hold_b;
  logic              unused_addr;

  assign idx_a       = port_a.addr[IW-1:0];
  assign idx_b       = port_b.addr[IW-1:0];
  assign unused_addr = ^{port_a.addr, port_b.addr};

  // B is scheduled first so A's later non-blocking byte write overrides on a shared word.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_b && port_b.we[b]) mem[idx_b][b*8 +: 8] <= port_b.di[b*8 +: 8];
      if (wr_a && port_a.we[b]) mem[idx_a][b*8 +: 8] <= port_a.di[b*8 +: 8];
    end
  end

  // RAM output registers double as the holding registers; non-blocking gives read-first.
  always_ff @(posedge CLK) begin
    if (rd_a) hold_a <= mem[idx_a];
  end

  always_ff @(posedge CLK) begin
    if (rd_b) hold_b <= mem[idx_b];
  end

  bram_port_ctl #(.DATA_W(DATA_W), .LAT(LAT)) u_ctl_a (
    .CLK    (CLK),
    .RST    (RST),
    .en     (port_a.en),
    .is_wr  (|port_a.we),
    .hold   (hold_a),
    .rdy    (port_a.rdy),
    .acc_wr (wr_a),
    .acc_rd (rd_a),
    .dout   (port_a.dout),
    .dvld   (port_a.dvld)
  );

  bram_port_ctl #(.DATA_W(DATA_W), .LAT(LAT)) u_ctl_b (
    .CLK    (CLK),
    .RST    (RST),
    .en     (port_b.en),
    .is_wr  (|port_b.we),
    .hold   (hold_b),
    .rdy    (port_b.rdy),
    .acc_wr (wr_b),
    .acc_rd (rd_b),
    .dout   (port_b.dout),
    .dvld   (port_b.dvld)
  );

endmodule

// File: tb/tb_bram_dp_lat.sv
// Bench for bram_dp_lat: a LAT=1 and a LAT=10 instance, scoreboard of expected read words per port.
module tb_bram_dp_lat;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // Port index: 0 = LAT1 A, 1 = LAT1 B, 2 = LAT10 A, 3 = LAT10 B
  logic        en   [4];
  logic [3:0]  we   [4];
  logic [31:0] addr [4];
  logic [31:0] di   [4];
  logic        rdy  [4];
  logic [31:0] dout [4];
  logic        dvld [4];

  logic [31:0] mdl [2][64];
  logic [31:0] expq [4][$];
  int          acc_cyc [4];
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;

  always @(posedge CLK) cyc = cyc + 1;

  bram_dp_lat_if #(.DATA_W(32), .ADDR_W(32)) if1a ();
  bram_dp_lat_if #(.DATA_W(32), .ADDR_W(32)) if1b ();
  bram_dp_lat_if #(.DATA_W(32), .ADDR_W(32)) if10a ();
  bram_dp_lat_if #(.DATA_W(32), .ADDR_W(32)) if10b ();

  assign if1a.en  = en[0];   assign if1a.we  = we[0];   assign if1a.addr  = addr[0];   assign if1a.di  = di[0];
  assign if1b.en  = en[1];   assign if1b.we  = we[1];   assign if1b.addr  = addr[1];   assign if1b.di  = di[1];
  assign if10a.en = en[2];   assign if10a.we = we[2];   assign if10a.addr = addr[2];   assign if10a.di = di[2];
  assign if10b.en = en[3];   assign if10b.we = we[3];   assign if10b.addr = addr[3];   assign if10b.di = di[3];
  assign rdy[0] = if1a.rdy;  assign dout[0] = if1a.dout;  assign dvld[0] = if1a.dvld;
  assign rdy[1] = if1b.rdy;  assign dout[1] = if1b.dout;  assign dvld[1] = if1b.dvld;
  assign rdy[2] = if10a.rdy; assign dout[2] = if10a.dout; assign dvld[2] = if10a.dvld;
  assign rdy[3] = if10b.rdy; assign dout[3] = if10b.dout; assign dvld[3] = if10b.dvld;

  bram_dp_lat #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .LAT(1)) dut1 (
    .CLK(CLK), .RST(RST), .port_a(if1a), .port_b(if1b)
  );
  bram_dp_lat #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .LAT(10)) dut10 (
    .CLK(CLK), .RST(RST), .port_a(if10a), .port_b(if10b)
  );

  // Drive a request and hold it until accepted. Reads capture the model before any same-edge write.
  task automatic issue(input int p, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge CLK);
    en[p] = 1'b1; we[p] = w; addr[p] = a; di[p] = d;
    n = 0;
    while (!rdy[p] && n < 50) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (rdy[p] !== 1'b1) begin
      $display("FAIL accept_timeout port%0d rdy=%b required 1", p, rdy[p]);
      errors++;
    end
    if (w == 4'h0) expq[p].push_back(mdl[p/2][a[5:0]]);
    @(posedge CLK);
    #1;
    acc_cyc[p] = cyc;
    for (int b = 0; b < 4; b++)
      if (w[b]) mdl[p/2][a[5:0]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic idle(input int p);
    @(negedge CLK);
    en[p] = 1'b0;
    we[p] = 4'h0;
  endtask

  task automatic wait_dvld(input int p, input int lat);
    int n;
    logic [31:0] e;
    n = 0;
    @(negedge CLK);
    while (!dvld[p] && n < 400) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (dvld[p] !== 1'b1) begin
      $display("FAIL dvld_timeout port%0d dvld=%b required 1", p, dvld[p]);
      errors++;
      if (expq[p].size() > 0) e = expq[p].pop_front();
      return;
    end
    vectors++;
    if (expq[p].size() == 0) begin
      $display("FAIL unexpected_dvld port%0d dout=%h required no read data", p, dout[p]);
      errors++;
      return;
    end
    e = expq[p].pop_front();
    if (dout[p] !== e) begin
      $display("FAIL rdata port%0d got %h required %h", p, dout[p], e);
      errors++;
    end
    vectors++;
    if (cyc - acc_cyc[p] != lat) begin
      $display("FAIL latency port%0d got %0d required %0d", p, cyc - acc_cyc[p], lat);
      errors++;
    end
  endtask

  task automatic test_reset;
    for (int p = 0; p < 4; p++) begin
      en[p] = 1'b0; we[p] = 4'h0; addr[p] = 32'h0; di[p] = 32'h0;
    end
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int p = 0; p < 4; p++) begin
      vectors++;
      if (rdy[p] !== 1'b1) begin $display("FAIL reset_rdy port%0d got %b required 1", p, rdy[p]); errors++; end
      vectors++;
      if (dvld[p] !== 1'b0) begin $display("FAIL reset_dvld port%0d got %b required 0", p, dvld[p]); errors++; end
      vectors++;
      if (dout[p] !== 32'h0) begin $display("FAIL reset_dout port%0d got %h required 0", p, dout[p]); errors++; end
    end
  endtask

  task automatic test_lat1;
    issue(0, 4'hF, 32'd5, 32'hDEADBEEF);
    idle(0);
    issue(0, 4'h0, 32'd5, 32'h0);
    idle(0);
    vectors++;
    if (rdy[0] !== 1'b1) begin $display("FAIL lat1_rdy got %b required 1", rdy[0]); errors++; end
    wait_dvld(0, 1);
    // Upper address bits are ignored: 69 aliases word 5 at DEPTH=64.
    issue(1, 4'h0, 32'd69, 32'h0);
    idle(1);
    wait_dvld(1, 1);
  endtask

  task automatic test_byte_enables;
    issue(0, 4'hF, 32'd12, 32'h11223344);
    issue(0, 4'b0101, 32'd12, 32'hAABBCCDD);
    issue(0, 4'h0, 32'd12, 32'h0);
    idle(0);
    wait_dvld(0, 1);
    vectors++;
    if (mdl[0][12] !== 32'h11BB33DD) begin $display("FAIL byte_model got %h required 11bb33dd", mdl[0][12]); errors++; end
    issue(2, 4'hF, 32'd12, 32'h11223344);
    issue(2, 4'b0101, 32'd12, 32'hAABBCCDD);
    issue(2, 4'h0, 32'd12, 32'h0);
    idle(2);
    wait_dvld(2, 10);
  endtask

  task automatic test_back_to_back;
    int t0;
    issue(3, 4'hF, 32'd7, 32'h77770007);
    issue(3, 4'h0, 32'd7, 32'h0);
    t0 = acc_cyc[3];
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      vectors++;
      if (rdy[3] !== 1'b0 || dvld[3] !== 1'b0) begin
        $display("FAIL b2b_wait edge+%0d rdy=%b dvld=%b required 0 0", k, rdy[3], dvld[3]);
        errors++;
      end
    end
    @(negedge CLK);
    vectors++;
    if (rdy[3] !== 1'b1) begin $display("FAIL b2b_done_rdy got %b required 1", rdy[3]); errors++; end
    expq[3].push_back(mdl[1][7]);
    @(posedge CLK);
    #1;
    acc_cyc[3] = cyc;
    @(negedge CLK);
    en[3] = 1'b0;
    vectors++;
    if (dvld[3] !== 1'b1 || cyc - t0 != 10) begin
      $display("FAIL b2b_first dvld=%b lat=%0d required 1 10", dvld[3], cyc - t0);
      errors++;
    end
    vectors++;
    if (dout[3] !== expq[3][0]) begin $display("FAIL b2b_first_data got %h required %h", dout[3], expq[3][0]); errors++; end
    if (expq[3].size() > 0) expq[3].pop_front();
    wait_dvld(3, 10);
  endtask

  task automatic test_same_edge_write;
    fork
      issue(0, 4'hF, 32'd3, 32'h00000001);
      issue(1, 4'hF, 32'd3, 32'h00000002);
    join
    fork idle(0); idle(1); join
    mdl[0][3] = 32'h00000001;
    issue(1, 4'h0, 32'd3, 32'h0);
    idle(1);
    wait_dvld(1, 1);
    fork
      issue(0, 4'b0011, 32'd3, 32'hAAAA5555);
      issue(1, 4'b1100, 32'd3, 32'h66667777);
    join
    fork idle(0); idle(1); join
    mdl[0][3] = 32'h66665555;
    issue(0, 4'h0, 32'd3, 32'h0);
    idle(0);
    wait_dvld(0, 1);
    fork
      issue(0, 4'b0110, 32'd3, 32'h11223344);
      issue(1, 4'b0011, 32'd3, 32'h55667788);
    join
    fork idle(0); idle(1); join
    mdl[0][3] = 32'h66223388;
    issue(1, 4'h0, 32'd3, 32'h0);
    idle(1);
    wait_dvld(1, 1);
  endtask

  task automatic test_read_first;
    issue(2, 4'hF, 32'd9, 32'h0);
    idle(2);
    fork
      issue(2, 4'hF, 32'd9, 32'h0000CAFE);
      issue(3, 4'h0, 32'd9, 32'h0);
    join
    fork idle(2); idle(3); join
    wait_dvld(3, 10);
    issue(3, 4'h0, 32'd9, 32'h0);
    idle(3);
    wait_dvld(3, 10);
  endtask

  task automatic test_reset_in_wait;
    int seen;
    logic [31:0] e;
    issue(3, 4'hF, 32'd20, 32'h12345678);
    issue(3, 4'h0, 32'd20, 32'h0);
    idle(3);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    vectors++;
    if (dvld[3] !== 1'b0 || dout[3] !== 32'h0 || rdy[3] !== 1'b1) begin
      $display("FAIL rst_wait dvld=%b dout=%h rdy=%b required 0 0 1", dvld[3], dout[3], rdy[3]);
      errors++;
    end
    if (expq[3].size() > 0) e = expq[3].pop_front();
    seen = 0;
    repeat (15) begin
      @(negedge CLK);
      if (dvld[3] === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin $display("FAIL rst_dropped_dvld got %0d pulses required 0", seen); errors++; end
    issue(3, 4'h0, 32'd20, 32'h0);
    idle(3);
    wait_dvld(3, 10);
  endtask

  initial begin
    test_reset();
    test_lat1();
    test_byte_enables();
    test_back_to_back();
    test_same_edge_write();
    test_read_first();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
